// File: rtl/player_y_ctrl_if.sv
// Bundle between the pitch front end (get_height side) and the player vertical controller.
// The master drives height/frame_tick; the slave returns the sprite position and status.
interface player_y_ctrl_if;
  logic [9:0] height;
  logic       frame_tick;
  logic [9:0] player_y;
  logic       y_valid;
  logic       on_floor;
  logic       silent;

  modport master (
    output height,
    output frame_tick,
    input  player_y,
    input  y_valid,
    input  on_floor,
    input  silent
  );

  modport slave (
    input  height,
    input  frame_tick,
    output player_y,
    output y_valid,
    output on_floor,
    output silent
  );
endinterface

// File: rtl/player_y_ctrl.sv
// Per-frame player sprite vertical control: moving-average of pitch height, target mapping,
// slew-limited tracking, gravity while silent, clamped to [0, FLOOR_Y].
module player_y_ctrl #(
  parameter int unsigned SCREEN_H   = 480,
  parameter int unsigned PLAYER_H   = 32,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned MAX_STEP   = 8,
  parameter int unsigned GRAVITY    = 4,
  parameter int unsigned SILENCE_TH = 10
) (
  input  logic           clk,
  input  logic           reset,
  player_y_ctrl_if.slave bus
);

  localparam int unsigned FloorY = SCREEN_H - PLAYER_H;
  localparam int unsigned Depth  = 1 << AVG_LOG2;
  localparam int unsigned SumW   = 10 + AVG_LOG2;

  // 11-bit copies so position arithmetic never wraps
  localparam logic [10:0] FloorW = 11'(FloorY);
  localparam logic [10:0] StepW  = 11'(MAX_STEP);
  localparam logic [10:0] GravW  = 11'(GRAVITY);
  localparam logic [9:0]  SilTh  = 10'(SILENCE_TH);

  typedef enum logic [1:0] {StIdle, StSum, StMove} state_e;

  state_e     state_q, state_d;
  logic [9:0] hist_q [Depth];
  logic [9:0] hist_d [Depth];
  logic [9:0] avg_q, avg_d;
  logic [9:0] target_q, target_d;
  logic       silent_q, silent_d;
  logic [9:0] player_y_q, player_y_d;
  logic       on_floor_q, on_floor_d;
  logic       y_valid_q, y_valid_d;

  logic [SumW-1:0] sum;
  logic [9:0]      avg_calc;
  logic [9:0]      target_calc;
  logic [10:0]     py_w, tgt_w, grav_y, diff, step, move_y;

  always_comb begin
    sum = '0;
    for (int i = 0; i < Depth; i++) begin
      sum = sum + SumW'(hist_q[i]);
    end
    avg_calc = 10'(sum >> AVG_LOG2);
    if ({1'b0, avg_calc} >= FloorW) begin
      target_calc = '0;
    end else begin
      target_calc = 10'(FloorW - {1'b0, avg_calc});
    end
  end

  // Next position for the MOVE edge; target never exceeds FLOOR_Y so tracking stays in range
  always_comb begin
    py_w   = {1'b0, player_y_q};
    tgt_w  = {1'b0, target_q};
    grav_y = py_w + GravW;
    diff   = '0;
    step   = '0;
    move_y = py_w;
    if (silent_q) begin
      move_y = (grav_y > FloorW) ? FloorW : grav_y;
    end else if (tgt_w > py_w) begin
      diff   = tgt_w - py_w;
      step   = (diff > StepW) ? StepW : diff;
      move_y = py_w + step;
    end else begin
      diff   = py_w - tgt_w;
      step   = (diff > StepW) ? StepW : diff;
      move_y = py_w - step;
    end
  end

  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    avg_d      = avg_q;
    target_d   = target_q;
    silent_d   = silent_q;
    player_y_d = player_y_q;
    on_floor_d = on_floor_q;
    y_valid_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.frame_tick) begin
          hist_d[0] = bus.height;
          for (int i = 1; i < Depth; i++) begin
            hist_d[i] = hist_q[i-1];
          end
          state_d = StSum;
        end
      end
      StSum: begin
        avg_d    = avg_calc;
        target_d = target_calc;
        silent_d = (avg_calc < SilTh);
        state_d  = StMove;
      end
      StMove: begin
        player_y_d = 10'(move_y);
        on_floor_d = (move_y == FloorW);
        y_valid_d  = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      hist_q     <= '{default: '0};
      avg_q      <= '0;
      target_q   <= '0;
      silent_q   <= 1'b1;
      player_y_q <= 10'(FloorY);
      on_floor_q <= 1'b1;
      y_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      avg_q      <= avg_d;
      target_q   <= target_d;
      silent_q   <= silent_d;
      player_y_q <= player_y_d;
      on_floor_q <= on_floor_d;
      y_valid_q  <= y_valid_d;
    end
  end

  assign bus.player_y = player_y_q;
  assign bus.y_valid  = y_valid_q;
  assign bus.on_floor = on_floor_q;
  assign bus.silent   = silent_q;

endmodule

// File: tb/tb_player_y_ctrl.sv
// Directed bench for player_y_ctrl: reset, tracking ramp, clamps, gravity, tick collision
// and mid-frame reset, with hand-computed expectations.
module tb_player_y_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  player_y_ctrl_if bus ();

  player_y_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame: tick at edge k, observe k+1 (avg/target/silent), k+2 (move), k+3 (pulse end)
  task automatic do_frame(input logic [9:0] h, output logic [9:0] a, output logic [9:0] t,
                          output logic s, output logic [9:0] p, output logic f);
    bus.height     = h;
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    bus.height     = 10'($urandom);
    check("yv_k0", 32'(bus.y_valid), 0);
    step();
    check("yv_k1", 32'(bus.y_valid), 0);
    a = dut.avg_q;
    t = dut.target_q;
    s = bus.silent;
    step();
    check("yv_k2", 32'(bus.y_valid), 1);
    p = bus.player_y;
    f = bus.on_floor;
    step();
    check("yv_k3", 32'(bus.y_valid), 0);
    repeat (6) step();
  endtask

  logic [9:0] a, t, p;
  logic       s, f;
  int         changes;
  int         exp_avg [4] = '{50, 100, 150, 200};
  int         exp_tgt [4] = '{398, 348, 298, 248};
  int         exp_py  [4] = '{440, 432, 424, 416};

  initial begin
    reset          = 1'b1;
    bus.height     = '0;
    bus.frame_tick = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    check("rst_py", 32'(bus.player_y), 448);
    check("rst_floor", 32'(bus.on_floor), 1);
    check("rst_silent", 32'(bus.silent), 1);
    check("rst_yv", 32'(bus.y_valid), 0);
    check("rst_avg", 32'(dut.avg_q), 0);
    check("rst_tgt", 32'(dut.target_q), 0);
    changes = 0;
    for (int i = 0; i < 100; i++) begin
      bus.height = 10'($urandom);
      step();
      if (bus.player_y != 10'd448 || bus.y_valid || !bus.on_floor || !bus.silent) changes++;
    end
    check("idle_stable", 32'(changes), 0);

    // Tracking ramp with height = 200
    for (int i = 0; i < 4; i++) begin
      do_frame(10'd200, a, t, s, p, f);
      check("ramp_avg", 32'(a), 32'(exp_avg[i]));
      check("ramp_tgt", 32'(t), 32'(exp_tgt[i]));
      check("ramp_silent", 32'(s), 0);
      check("ramp_py", 32'(p), 32'(exp_py[i]));
    end
    for (int i = 1; i <= 21; i++) begin
      do_frame(10'd200, a, t, s, p, f);
      check("ramp_py", 32'(p), 32'(416 - 8 * i));
    end
    do_frame(10'd200, a, t, s, p, f);
    check("ramp_hold", 32'(p), 248);
    check("ramp_floor", 32'(f), 0);

    // Bring player to 300 (avg 148)
    repeat (7) do_frame(10'd148, a, t, s, p, f);
    check("to300_py", 32'(p), 300);

    // Top clamp with height = 1023
    do_frame(10'd1023, a, t, s, p, f);
    check("top_t1", 32'(t), 82);
    check("top_p1", 32'(p), 292);
    repeat (3) do_frame(10'd1023, a, t, s, p, f);
    check("top_avg", 32'(a), 1023);
    check("top_tgt", 32'(t), 0);
    check("top_p4", 32'(p), 268);
    repeat (33) do_frame(10'd1023, a, t, s, p, f);
    check("top_p_pre", 32'(p), 4);
    do_frame(10'd1023, a, t, s, p, f);
    check("top_p_zero", 32'(p), 0);
    do_frame(10'd1023, a, t, s, p, f);
    check("top_p_hold", 32'(p), 0);

    // Back down to 300
    do_frame(10'd148, a, t, s, p, f);
    check("back_p1", 32'(p), 0);
    do_frame(10'd148, a, t, s, p, f);
    do_frame(10'd148, a, t, s, p, f);
    check("back_p3", 32'(p), 8);
    do_frame(10'd148, a, t, s, p, f);
    check("back_p4", 32'(p), 16);
    repeat (36) do_frame(10'd148, a, t, s, p, f);
    check("back_300", 32'(p), 300);

    // Gravity: average decays before silence kicks in
    do_frame(10'd0, a, t, s, p, f);
    check("grav_avg1", 32'(a), 111);
    check("grav_p1", 32'(p), 308);
    do_frame(10'd0, a, t, s, p, f);
    check("grav_p2", 32'(p), 316);
    do_frame(10'd0, a, t, s, p, f);
    check("grav_sil3", 32'(s), 0);
    check("grav_p3", 32'(p), 324);
    do_frame(10'd0, a, t, s, p, f);
    check("grav_sil4", 32'(s), 1);
    check("grav_p4", 32'(p), 328);
    check("grav_floor4", 32'(f), 0);
    for (int i = 1; i <= 30; i++) begin
      do_frame(10'd0, a, t, s, p, f);
      check("grav_py", 32'(p), 32'(328 + 4 * i));
    end
    check("grav_floor", 32'(f), 1);
    do_frame(10'd0, a, t, s, p, f);
    check("grav_sat", 32'(p), 448);

    // Tick collision: frame_tick held k..k+3, only k and k+3 accepted
    bus.frame_tick = 1'b1;
    bus.height     = 10'd500;
    step();
    bus.height = 10'd900;
    step();
    check("col_yv1", 32'(bus.y_valid), 0);
    check("col_avg1", 32'(dut.avg_q), 125);
    check("col_tgt1", 32'(dut.target_q), 323);
    step();
    check("col_yv2", 32'(bus.y_valid), 1);
    check("col_py2", 32'(bus.player_y), 440);
    bus.height = 10'd100;
    step();
    check("col_yv3", 32'(bus.y_valid), 0);
    bus.frame_tick = 1'b0;
    step();
    check("col_avg4", 32'(dut.avg_q), 150);
    check("col_tgt4", 32'(dut.target_q), 298);
    step();
    check("col_yv5", 32'(bus.y_valid), 1);
    check("col_py5", 32'(bus.player_y), 432);
    repeat (4) step();

    // Mid-operation reset
    bus.frame_tick = 1'b1;
    bus.height     = 10'd800;
    step();
    bus.frame_tick = 1'b0;
    reset          = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_py", 32'(bus.player_y), 448);
    check("mrst_silent", 32'(bus.silent), 1);
    check("mrst_floor", 32'(bus.on_floor), 1);
    check("mrst_avg", 32'(dut.avg_q), 0);
    step();
    check("mrst_yv", 32'(bus.y_valid), 0);
    check("mrst_py2", 32'(bus.player_y), 448);
    repeat (3) step();

    // Silence threshold boundary on cleared history: avg 9 silent, avg 10 not
    do_frame(10'd36, a, t, s, p, f);
    check("th9_avg", 32'(a), 9);
    check("th9_sil", 32'(s), 1);
    check("th9_py", 32'(p), 448);
    do_frame(10'd4, a, t, s, p, f);
    check("th10_avg", 32'(a), 10);
    check("th10_sil", 32'(s), 0);
    check("th10_tgt", 32'(t), 438);
    check("th10_py", 32'(p), 440);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
